s2_word_accumulator: RTL and testbench

Downstream consumer of the registered mux stage. Takes the registered size-bit word that stage produces and sums a frame of COUNT valid words into a wider accumulator. Start/busy/done handshake towards the controller. Sticky overflow flag per frame.

---
 rtl/s2_word_accumulator.sv | 113 +++++++++++
 tb/tb_s2_word_accumulator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/s2_word_accumulator.sv
// Frame accumulator fed by the registered mux stage: sums COUNT valid words per start.
// Optional macro ACC_SAT_EN clamps acc to all-ones on carry-out instead of wrapping.
module s2_word_accumulator #(
  parameter int unsigned size  = 5,
  parameter int unsigned COUNT = 4,
  parameter int unsigned ACC_W = 7
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             start,
  input  logic             in_valid,
  input  logic [size-1:0]  din,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc,
  output logic [7:0]       cnt,
  output logic             ovf
);

  // Sum is wide enough that every bit above ACC_W-1 is a carry-out, even when size > ACC_W.
  localparam int unsigned SUM_W = ((ACC_W > size) ? ACC_W : size) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [SUM_W-1:0] sum;
  logic             carry;
  logic             last_word;

  always_comb begin
    sum       = SUM_W'(acc_q) + SUM_W'(din);
    carry     = |sum[SUM_W-1:ACC_W];
    last_word = (cnt_q == 8'(COUNT - 1));
  end

  always_ff @(posedge clk or posedge CLR) begin
    if (CLR) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          cnt_d = cnt_q + 8'd1;
`ifdef ACC_SAT_EN
          // Once clamped, any further nonzero word carries again, so acc stays all-ones.
          acc_d = carry ? '1 : sum[ACC_W-1:0];
`else
          acc_d = sum[ACC_W-1:0];
`endif
          if (carry) begin
            ovf_d = 1'b1;
          end
          if (last_word) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so they align with it.
    busy_d = (state_d == S_ACCUM);
    done_d = (state_d == S_DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign acc  = acc_q;
  assign cnt  = cnt_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_s2_word_accumulator.sv
// Directed bench for s2_word_accumulator: COUNT=4 at ACC_W=7 and ACC_W=6, plus a COUNT=1 instance.
module tb_s2_word_accumulator;

  logic       clk = 1'b0;
  logic       CLR = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [4:0] din = '0;
  logic       start1 = 1'b0;
  logic       in_valid1 = 1'b0;
  logic [4:0] din1 = '0;

  logic       busy7, done7, ovf7;
  logic [6:0] acc7;
  logic [7:0] cnt7;
  logic       busy6, done6, ovf6;
  logic [5:0] acc6;
  logic [7:0] cnt6;
  logic       busy1, done1, ovf1;
  logic [6:0] acc1;
  logic [7:0] cnt1;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  s2_word_accumulator #(.size(5), .COUNT(4), .ACC_W(7)) dut7 (
    .clk(clk), .CLR(CLR), .start(start), .in_valid(in_valid), .din(din),
    .busy(busy7), .done(done7), .acc(acc7), .cnt(cnt7), .ovf(ovf7)
  );

  s2_word_accumulator #(.size(5), .COUNT(4), .ACC_W(6)) dut6 (
    .clk(clk), .CLR(CLR), .start(start), .in_valid(in_valid), .din(din),
    .busy(busy6), .done(done6), .acc(acc6), .cnt(cnt6), .ovf(ovf6)
  );

  s2_word_accumulator #(.size(5), .COUNT(1), .ACC_W(7)) dut1 (
    .clk(clk), .CLR(CLR), .start(start1), .in_valid(in_valid1), .din(din1),
    .busy(busy1), .done(done1), .acc(acc1), .cnt(cnt1), .ovf(ovf1)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [4:0] w);
    in_valid = 1'b1;
    din      = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic begin_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Test 1: reset, then four 31s back to back
    CLR = 1'b1;
    #3;
    check("rst_acc", acc7, 0);
    check("rst_cnt", cnt7, 0);
    check("rst_ovf", ovf7, 0);
    check("rst_busy", busy7, 0);
    check("rst_done", done7, 0);
    tick();
    CLR = 1'b0;
    tick();
    begin_frame();
    check("t1_busy_start", busy7, 1);
    check("t1_acc_clear", acc7, 0);
    for (int i = 0; i < 3; i++) begin
      word(5'd31);
      check("t1_busy_mid", busy7, 1);
      check("t1_done_mid", done7, 0);
    end
    check("t1_acc_3", acc7, 93);
    check("t1_cnt_3", cnt7, 3);
    word(5'd31);
    check("t1_done", done7, 1);
    check("t1_busy_done", busy7, 0);
    check("t1_acc", acc7, 124);
    check("t1_cnt", cnt7, 4);
    check("t1_ovf", ovf7, 0);
`ifdef ACC_SAT_EN
    check("t3_acc6", acc6, 63);
`else
    check("t3_acc6", acc6, 60);
`endif
    check("t3_ovf6", ovf6, 1);
    check("t3_done6", done6, 1);
    tick();
    check("t1_idle_done", done7, 0);
    check("t1_idle_busy", busy7, 0);
    check("t1_idle_acc", acc7, 124);
    tick();
    check("t1_idle_acc2", acc7, 124);

    // Test 2: gaps between valid words
    begin_frame();
    check("t2_ovf6_clear", ovf6, 0);
    word(5'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t2_gap_acc", acc7, 1);
      check("t2_gap_cnt", cnt7, 1);
      check("t2_gap_busy", busy7, 1);
    end
    word(5'd2);
    word(5'd3);
    check("t2_acc_3", acc7, 6);
    word(5'd4);
    check("t2_done", done7, 1);
    check("t2_acc", acc7, 10);
    check("t2_acc6", acc6, 10);
    check("t2_ovf6", ovf6, 0);
    tick();

    // Test 4: start pulse during ACCUM is ignored
    begin_frame();
    word(5'd5);
    word(5'd6);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_acc_hold", acc7, 11);
    check("t4_cnt_hold", cnt7, 2);
    check("t4_busy", busy7, 1);
    word(5'd7);
    check("t4_no_early_done", done7, 0);
    word(5'd8);
    check("t4_done", done7, 1);
    check("t4_acc", acc7, 26);
    check("t4_cnt", cnt7, 4);
    tick();
    check("t4_single_done", done7, 0);
    tick();
    check("t4_single_done2", done7, 0);

    // Test 5: asynchronous clear mid-frame
    begin_frame();
    word(5'd20);
    word(5'd30);
    check("t5_acc_pre", acc7, 50);
    #2;
    CLR = 1'b1;
    #1;
    check("t5_async_acc", acc7, 0);
    check("t5_async_cnt", cnt7, 0);
    check("t5_async_ovf6", ovf6, 0);
    check("t5_async_busy", busy7, 0);
    tick();
    check("t5_no_done", done7, 0);
    CLR = 1'b0;
    tick();
    check("t5_idle_busy", busy7, 0);
    check("t5_idle_done", done7, 0);
    begin_frame();
    for (int i = 0; i < 4; i++) word(5'd1);
    check("t5_done", done7, 1);
    check("t5_acc", acc7, 4);
    tick();

    // Test 6: COUNT=1, start held through DONE
    start1 = 1'b1;
    tick();
    check("t6_busy", busy1, 1);
    in_valid1 = 1'b1;
    din1      = 5'd9;
    tick();
    in_valid1 = 1'b0;
    check("t6_done", done1, 1);
    check("t6_acc", acc1, 9);
    check("t6_cnt", cnt1, 1);
    tick();
    check("t6_idle_done", done1, 0);
    check("t6_idle_busy", busy1, 0);
    check("t6_idle_acc", acc1, 9);
    tick();
    start1 = 1'b0;
    check("t6_restart_busy", busy1, 1);
    check("t6_restart_acc", acc1, 0);
    check("t6_restart_cnt", cnt1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
